// File: rtl/mult_seq_pkg.sv
// Shared types and sizing for the shift-and-add multiplier sequencer.
// Holds the FSM state encoding, default operand width and counter sizing.
package mult_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    VALID   = 3'd4
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter must hold 0..WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mult_sequencer.sv
// Load/shift sequencer for a WIDTH-bit shift-and-add multiplier datapath.
// Optional macro MULT_SEQ_ZERO_SKIP_EN: zero operands bypass the datapath.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  output logic                 mult_ld,
  output logic                 mult_ctrl,
  input  logic [2*WIDTH-1:0]   mult_pq,
  output logic [2*WIDTH-1:0]   prod_out,
  output logic                 prod_valid,
  input  logic                 prod_ready
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic                 valid_reg, valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      prod_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      prod_reg  <= prod_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    prod_next  = prod_reg;
    valid_next = valid_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          a_next = a_in;
          b_next = b_in;
`ifdef MULT_SEQ_ZERO_SKIP_EN
          if ((a_in == '0) || (b_in == '0)) begin
            prod_next  = '0;
            valid_next = 1'b1;
            state_next = VALID;
          end else begin
            state_next = LOAD;
          end
`else
          state_next = LOAD;
`endif
        end
      end

      LOAD: begin
        cnt_next   = '0;
        state_next = RUN;
      end

      // One datapath shift per cycle; leave after the WIDTH-th shift.
      RUN: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        prod_next  = mult_pq;
        valid_next = 1'b1;
        state_next = VALID;
      end

      VALID: begin
        if (prod_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes are pure state decodes, so they can never overlap.
  assign busy       = (state_reg != IDLE);
  assign mult_ld    = (state_reg == LOAD);
  assign mult_ctrl  = (state_reg == RUN);
  assign mult_a     = a_reg;
  assign mult_b     = b_reg;
  assign prod_out   = prod_reg;
  assign prod_valid = valid_reg;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shift-and-add datapath.
// Expectations follow MULT_SEQ_ZERO_SKIP_EN when it is defined.
module tb_mult_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a_in, b_in;
  logic           busy;
  logic [W-1:0]   mult_a, mult_b;
  logic           mult_ld, mult_ctrl;
  logic [2*W-1:0] mult_pq;
  logic [2*W-1:0] prod_out;
  logic           prod_valid;
  logic           prod_ready;

  int n_cmp = 0;
  int n_err = 0;
  int ld_cnt = 0;
  int ctrl_cnt = 0;
  int overlap_cnt = 0;
  int edges;
  logic [2*W-1:0] held;

  always #5 clk = ~clk;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_ld    (mult_ld),
    .mult_ctrl  (mult_ctrl),
    .mult_pq    (mult_pq),
    .prod_out   (prod_out),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready)
  );

  // Shift-and-add datapath: P accumulates M when Q[0] is set, then {C,P,Q} shifts right.
  logic [W-1:0] dp_p, dp_q, dp_m;
  logic [W:0]   dp_sum;
  always_comb dp_sum = {1'b0, dp_p} + (dp_q[0] ? {1'b0, dp_m} : {(W+1){1'b0}});
  always_ff @(posedge clk) begin
    if (mult_ld) begin
      dp_p <= '0;
      dp_q <= mult_a;
      dp_m <= mult_b;
    end else if (mult_ctrl) begin
      dp_p <= dp_sum[W:1];
      dp_q <= {dp_sum[0], dp_q[W-1:1]};
    end
  end
  assign mult_pq = {dp_p, dp_q};

  always @(negedge clk) begin
    if (mult_ld) ld_cnt++;
    if (mult_ctrl) ctrl_cnt++;
    if (mult_ld && mult_ctrl) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge 1 samples start; counts edges until prod_valid is seen (bounded).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    a_in = a; b_in = b; start = 1'b1;
    ld_cnt = 0; ctrl_cnt = 0;
    step();
    start = 1'b0;
    n = 1;
    while (!prod_valid && n < 40) begin
      step();
      n++;
    end
    chk("valid_seen", {31'd0, prod_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; prod_ready = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld_ctrl", {30'd0, mult_ld, mult_ctrl}, 32'd0);
    chk("rst_ops", {24'd0, mult_a, mult_b}, 32'd0);
    chk("rst_prod", {23'd0, prod_valid, prod_out}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: 13*11, cycle-exact sequence and one-cycle valid
    prod_ready = 1'b1;
    a_in = 4'd13; b_in = 4'd11; start = 1'b1;
    ld_cnt = 0; ctrl_cnt = 0;
    step();                                   // edge 1
    start = 1'b0;
    chk("t1_ld", {30'd0, mult_ld, mult_ctrl}, 32'd2);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin         // edges 2..5
      step();
      chk("t1_ctrl", {30'd0, mult_ld, mult_ctrl}, 32'd1);
    end
    chk("t1_ops_stable", {24'd0, mult_a, mult_b}, {24'd0, 4'd13, 4'd11});
    step();                                   // edge 6: CAPTURE
    chk("t1_capture", {29'd0, mult_ld, mult_ctrl, prod_valid}, 32'd0);
    step();                                   // edge 7
    chk("t1_valid", {31'd0, prod_valid}, 32'd1);
    chk("t1_prod", {24'd0, prod_out}, 32'h8F);
    step();                                   // edge 8: accepted
    chk("t1_valid_drop", {30'd0, prod_valid, busy}, 32'd0);
    chk("t1_pulses", ld_cnt * 16 + ctrl_cnt, 32'd20);

    // 2: 15*15 with consumer stall
    prod_ready = 1'b0;
    launch(4'd15, 4'd15, edges);
    chk("t2_latency", edges, 32'd7);
    chk("t2_prod", {24'd0, prod_out}, 32'hE1);
    held = prod_out;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_stall_hold", {23'd0, prod_valid, prod_out}, {23'd0, 1'b1, held});
    end
    prod_ready = 1'b1;
    step();
    chk("t2_accept", {30'd0, prod_valid, busy}, 32'd0);

    // 3: zero operand
    launch(4'd0, 4'd9, edges);
    chk("t3_prod", {24'd0, prod_out}, 32'h00);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    chk("t3_latency", edges, 32'd1);
    chk("t3_pulses", ld_cnt * 16 + ctrl_cnt, 32'd0);
    chk("t3_ops_latched", {24'd0, mult_a, mult_b}, {24'd0, 4'd0, 4'd9});
`else
    chk("t3_latency", edges, 32'd7);
    chk("t3_pulses", ld_cnt * 16 + ctrl_cnt, 32'd20);
`endif
    step();
    chk("t3_accept", {31'd0, busy}, 32'd0);

    // 4: start during RUN is ignored
    a_in = 4'd5; b_in = 4'd6; start = 1'b1;
    step();                                   // edge 1
    start = 1'b0;
    step(); step();                           // now in RUN
    a_in = 4'd2; b_in = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_busy_run", {31'd0, busy}, 32'd1);
    edges = 0;
    while (!prod_valid && edges < 40) begin
      chk("t4_busy_hold", {31'd0, busy}, 32'd1);
      step();
      edges++;
    end
    chk("t4_prod", {24'd0, prod_out}, 32'h1E);
    chk("t4_ops", {24'd0, mult_a, mult_b}, {24'd0, 4'd5, 4'd6});
    step(); step();
    chk("t4_no_queue", {31'd0, busy}, 32'd0);

    // 5: asynchronous reset mid-RUN, then 7*9
    a_in = 4'd5; b_in = 4'd5; start = 1'b1;
    step();                                   // edge 1
    start = 1'b0;
    step(); step(); step();                   // edge 4: cnt==2
    chk("t5_in_run", {31'd0, mult_ctrl}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ctrl", {29'd0, busy, mult_ld, mult_ctrl}, 32'd0);
    chk("t5_rst_data", {15'd0, prod_valid, mult_a, mult_b, prod_out}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    launch(4'd7, 4'd9, edges);
    chk("t5_latency", edges, 32'd7);
    chk("t5_prod", {24'd0, prod_out}, 32'h3F);
    step();

    // 6: back-to-back with start held high
    launch(4'd1, 4'd1, edges);
    start = 1'b1;
    chk("t6_first", {24'd0, prod_out}, 32'h01);
    a_in = 4'd3; b_in = 4'd5;
    step();                                   // accept edge: start ignored
    chk("t6_idle", {31'd0, busy}, 32'd0);
    step();                                   // first IDLE cycle takes start
    start = 1'b0;
    chk("t6_second_ld", {31'd0, mult_ld}, 32'd1);
    edges = 1;
    while (!prod_valid && edges < 40) begin
      step();
      edges++;
    end
    chk("t6_second_latency", edges, 32'd7);
    chk("t6_second", {24'd0, prod_out}, 32'h0F);
    step();
    chk("t6_done", {31'd0, busy}, 32'd0);
    chk("no_overlap", overlap_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
